ase_mode_fifo: RTL and testbench

//  Parametrised single-clock FIFO for ASE channel buffering; successor to the fixed-latency ASE FIFO.

---
 rtl/ase_fifo_pkg.sv | 8 +
 rtl/ase_fifo_ram.sv | 28 ++
 rtl/ase_mode_fifo.sv | 139 +++++++++++++
 tb/tb_ase_mode_fifo.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ase_fifo_pkg.sv
// Shared types for the ASE channel FIFO: read-mode select and FWFT head state.
package ase_fifo_pkg;

   typedef enum logic {ASE_FIFO_STD, ASE_FIFO_FWFT} ase_fifo_mode_t;

   typedef enum logic {EMPTY_HEAD, VALID_HEAD} ase_fifo_head_t;

endpackage

// File: rtl/ase_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port that holds its
// output while the read enable is low. Deliberately unreset.
module ase_fifo_ram
   import ase_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd_en,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ase_mode_fifo.sv
// Single-clock ASE channel FIFO with STD or FWFT read mode, exact occupancy,
// threshold flags and sticky overflow/underflow errors.
module ase_mode_fifo
   import ase_fifo_pkg::*;
#(
   parameter int unsigned    DATA_WIDTH      = 64,
   parameter int unsigned    DEPTH_BASE2     = 4,
   parameter int unsigned    ALMFULL_THRESH  = 12,
   parameter int unsigned    ALMEMPTY_THRESH = 2,
   parameter ase_fifo_mode_t MODE            = ASE_FIFO_STD
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_wr_en,
   input  logic [DATA_WIDTH-1:0] i_data_in,
   input  logic                  i_rd_en,
   input  logic                  i_err_clr,
   output logic [DATA_WIDTH-1:0] o_data_out,
   output logic                  o_data_out_v,
   output logic                  o_full,
   output logic                  o_alm_full,
   output logic                  o_empty,
   output logic                  o_alm_empty,
   output logic [DEPTH_BASE2:0]  o_count,
   output logic                  o_overflow,
   output logic                  o_underflow,
   output logic [1:0]            o_err_sticky
);

   localparam int unsigned          DEPTH    = 2**DEPTH_BASE2;
   localparam logic [DEPTH_BASE2:0] FULL_CNT = DEPTH[DEPTH_BASE2:0];
   localparam logic [DEPTH_BASE2:0] AF_CNT   = ALMFULL_THRESH[DEPTH_BASE2:0];
   localparam logic [DEPTH_BASE2:0] AE_CNT   = ALMEMPTY_THRESH[DEPTH_BASE2:0];

   if (ALMFULL_THRESH > DEPTH) begin : g_chk_af
      $error("%m: ALMFULL_THRESH exceeds FIFO capacity");
   end
   if (ALMEMPTY_THRESH >= ALMFULL_THRESH) begin : g_chk_ae
      $error("%m: ALMEMPTY_THRESH must be below ALMFULL_THRESH");
   end

   logic [DEPTH_BASE2-1:0] r_wr_ptr;
   logic [DEPTH_BASE2-1:0] r_rd_ptr;
   logic [DEPTH_BASE2:0]   r_count;
   ase_fifo_head_t         r_head;
   logic                   r_std_v;
   logic                   r_seen;
   logic                   r_ovf;
   logic                   r_udf;
   logic [1:0]             r_err;

   logic                   w_head_v;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_wr_ok;
   logic                   w_rd_ok;
   logic                   w_ram_rd;
   logic [DEPTH_BASE2:0]   w_ram_words;
   logic [DATA_WIDTH-1:0]  w_ram_q;

   assign w_head_v    = (MODE == ASE_FIFO_FWFT) && (r_head == VALID_HEAD);
   assign w_full      = (r_count == FULL_CNT);
   assign w_empty     = (MODE == ASE_FIFO_FWFT) ? !w_head_v : (r_count == '0);
   assign w_wr_ok     = i_wr_en && !w_full;
   assign w_rd_ok     = i_rd_en && !w_empty;
   // In FWFT mode the head word lives in the RAM read register, not in the array.
   assign w_ram_words = r_count - {{DEPTH_BASE2{1'b0}}, w_head_v};
   assign w_ram_rd    = (MODE == ASE_FIFO_FWFT) ?
                        ((!w_head_v || w_rd_ok) && (w_ram_words != '0)) : w_rd_ok;

   ase_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (DEPTH_BASE2)
   ) u_ram (
      .clk       (clk),
      .i_wr_en   (w_wr_ok),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (i_data_in),
      .i_rd_en   (w_ram_rd),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_ram_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_std_v  <= 1'b0;
         r_seen   <= 1'b0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
         r_err    <= 2'b00;
      end else begin
         if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_ram_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_wr_ok && !w_rd_ok) r_count <= r_count + 1'b1;
         else if (!w_wr_ok && w_rd_ok) r_count <= r_count - 1'b1;
         // Unreset RAM output is masked until the first fetch lands in it.
         if (w_ram_rd) r_seen <= 1'b1;
         r_std_v  <= w_rd_ok;
         r_ovf    <= i_wr_en && w_full;
         r_udf    <= i_rd_en && w_empty;
         r_err[1] <= (i_wr_en && w_full) || (r_err[1] && !i_err_clr);
         r_err[0] <= (i_rd_en && w_empty) || (r_err[0] && !i_err_clr);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head <= EMPTY_HEAD;
      end else if (MODE == ASE_FIFO_FWFT) begin
         case (r_head)
            EMPTY_HEAD: if (w_ram_rd) r_head <= VALID_HEAD;
            VALID_HEAD: if (w_rd_ok && !w_ram_rd) r_head <= EMPTY_HEAD;
            default:    r_head <= EMPTY_HEAD;
         endcase
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (r_ovf) $display("%m: overflow, write dropped");
      if (r_udf) $display("%m: underflow, read dropped");
   end
`endif

   assign o_data_out   = r_seen ? w_ram_q : '0;
   assign o_data_out_v = (MODE == ASE_FIFO_FWFT) ? w_head_v : r_std_v;
   assign o_full       = w_full;
   assign o_alm_full   = (r_count >= AF_CNT);
   assign o_empty      = w_empty;
   assign o_alm_empty  = (r_count <= AE_CNT);
   assign o_count      = r_count;
   assign o_overflow   = r_ovf;
   assign o_underflow  = r_udf;
   assign o_err_sticky = r_err;

endmodule

// File: tb/tb_ase_mode_fifo.sv
// Directed bench for ase_mode_fifo: one STD and one FWFT instance, hand-computed expectations.
module tb_ase_mode_fifo;
   import ase_fifo_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        s_wr = 1'b0, s_rd = 1'b0, s_clr = 1'b0;
   logic [63:0] s_din = '0;
   logic [63:0] s_dout;
   logic        s_dv, s_full, s_afull, s_empty, s_aempty, s_ovf, s_udf;
   logic [4:0]  s_cnt;
   logic [1:0]  s_err;

   logic        f_wr = 1'b0, f_rd = 1'b0, f_clr = 1'b0;
   logic [63:0] f_din = '0;
   logic [63:0] f_dout;
   logic        f_dv, f_full, f_afull, f_empty, f_aempty, f_ovf, f_udf;
   logic [4:0]  f_cnt;
   logic [1:0]  f_err;

   ase_mode_fifo #(.MODE(ASE_FIFO_STD)) u_std (
      .clk(clk), .rst_n(rst_n), .i_wr_en(s_wr), .i_data_in(s_din), .i_rd_en(s_rd),
      .i_err_clr(s_clr), .o_data_out(s_dout), .o_data_out_v(s_dv), .o_full(s_full),
      .o_alm_full(s_afull), .o_empty(s_empty), .o_alm_empty(s_aempty), .o_count(s_cnt),
      .o_overflow(s_ovf), .o_underflow(s_udf), .o_err_sticky(s_err)
   );

   ase_mode_fifo #(.MODE(ASE_FIFO_FWFT)) u_fwft (
      .clk(clk), .rst_n(rst_n), .i_wr_en(f_wr), .i_data_in(f_din), .i_rd_en(f_rd),
      .i_err_clr(f_clr), .o_data_out(f_dout), .o_data_out_v(f_dv), .o_full(f_full),
      .o_alm_full(f_afull), .o_empty(f_empty), .o_alm_empty(f_aempty), .o_count(f_cnt),
      .o_overflow(f_ovf), .o_underflow(f_udf), .o_err_sticky(f_err)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tick();
      tick();
      check("rst_cnt", s_cnt, 0);
      check("rst_empty", s_empty, 1);
      check("rst_aempty", s_aempty, 1);
      check("rst_full", s_full, 0);
      check("rst_afull", s_afull, 0);
      check("rst_dout", s_dout, 0);
      check("rst_dv", s_dv, 0);
      check("rst_err", s_err, 0);
      check("rst_f_empty", f_empty, 1);
      check("rst_f_dout", f_dout, 0);
      rst_n = 1'b1;
      tick();

      // Reset mid-burst
      for (int i = 0; i < 8; i++) begin
         s_wr = 1'b1; s_din = 64'(i);
         tick();
      end
      check("burst_cnt", s_cnt, 8);
      s_wr = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mid_rst_cnt", s_cnt, 0);
      check("mid_rst_empty", s_empty, 1);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_ovf", s_ovf, 0);
      check("post_rst_udf", s_udf, 0);
      check("post_rst_dv", s_dv, 0);
      check("post_rst_cnt", s_cnt, 0);

      // STD fill 0x0..0xF
      for (int i = 0; i < 16; i++) begin
         s_wr = 1'b1; s_din = 64'(i);
         tick();
         check("fill_cnt", s_cnt, 64'(i + 1));
         check("fill_afull", s_afull, (i + 1 >= 12));
         check("fill_aempty", s_aempty, (i + 1 <= 2));
         check("fill_full", s_full, (i + 1 == 16));
      end
      s_din = 64'h99;
      tick();
      s_wr = 1'b0;
      check("ovf_pulse", s_ovf, 1);
      check("ovf_cnt", s_cnt, 16);
      check("ovf_err", s_err, 2'b10);
      tick();
      check("ovf_pulse_end", s_ovf, 0);
      check("ovf_err_held", s_err, 2'b10);
      s_clr = 1'b1;
      tick();
      s_clr = 1'b0;
      check("clr_err", s_err, 2'b00);

      // STD drain
      for (int i = 0; i < 16; i++) begin
         s_rd = 1'b1;
         tick();
         check("drain_dv", s_dv, 1);
         check("drain_data", s_dout, 64'(i));
         check("drain_cnt", s_cnt, 64'(15 - i));
         check("drain_aempty", s_aempty, (15 - i <= 2));
      end
      tick();
      s_rd = 1'b0;
      check("udf_pulse", s_udf, 1);
      check("udf_dv", s_dv, 0);
      check("udf_empty", s_empty, 1);
      check("udf_hold", s_dout, 64'hF);
      check("udf_err", s_err, 2'b01);
      tick();
      check("udf_pulse_end", s_udf, 0);
      s_clr = 1'b1;
      tick();
      s_clr = 1'b0;

      // Simultaneous write+read at full
      for (int i = 0; i < 16; i++) begin
         s_wr = 1'b1; s_din = 64'h100 + 64'(i);
         tick();
      end
      check("refill_full", s_full, 1);
      s_rd = 1'b1; s_din = 64'hDEAD;
      tick();
      s_wr = 1'b0; s_rd = 1'b0;
      check("wr_rd_full_cnt", s_cnt, 15);
      check("wr_rd_full_ovf", s_ovf, 1);
      check("wr_rd_full_dv", s_dv, 1);
      check("wr_rd_full_data", s_dout, 64'h100);
      check("wr_rd_full_err", s_err, 2'b10);
      s_clr = 1'b1;
      tick();
      s_clr = 1'b0;
      check("final_clr", s_err, 2'b00);

      // FWFT single word
      f_wr = 1'b1; f_din = 64'hA5;
      tick();
      f_wr = 1'b0;
      check("fwft_e0_cnt", f_cnt, 1);
      check("fwft_e0_dv", f_dv, 0);
      check("fwft_e0_empty", f_empty, 1);
      tick();
      check("fwft_e1_dv", f_dv, 1);
      check("fwft_e1_data", f_dout, 64'hA5);
      check("fwft_e1_empty", f_empty, 0);
      f_rd = 1'b1;
      tick();
      f_rd = 1'b0;
      check("fwft_pop_dv", f_dv, 0);
      check("fwft_pop_empty", f_empty, 1);
      check("fwft_pop_cnt", f_cnt, 0);

      // FWFT steady stream at count 8
      for (int i = 0; i < 8; i++) begin
         f_wr = 1'b1; f_din = 64'h200 + 64'(i);
         tick();
      end
      f_wr = 1'b0;
      tick();
      check("stream_cnt0", f_cnt, 8);
      check("stream_head0", f_dout, 64'h200);
      for (int k = 0; k < 100; k++) begin
         f_wr = 1'b1; f_rd = 1'b1; f_din = 64'h208 + 64'(k);
         tick();
         check("stream_cnt", f_cnt, 8);
         check("stream_dv", f_dv, 1);
         check("stream_data", f_dout, 64'h201 + 64'(k));
      end
      f_wr = 1'b0; f_rd = 1'b0;
      check("stream_ovf", f_ovf, 0);
      check("stream_err", f_err, 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
